lcd_init_sequencer: RTL and testbench
=====================================

# lcd_init_sequencer

Front-end stage that feeds `lcd_controller`. It runs the HD44780 power-on and 4-bit init sequence, then accepts characters from user logic through a valid/ready handshake. Each character or command goes to the controller as a one-cycle strobe, and the block waits for the controller's `done` before the next one. It tracks the cursor over a 2x16 display and inserts the line-change commands.

## Interface
- `CLK_PERIOD_NS`, 20 — clock period; driven on `period_clk_ns` and used for all delay math.
- `POWERUP_US`, 15000 — wait after reset before the first command.
- `CMD_US`, 40 — settle delay after every command or character.
- `CLEAR_US`, 1640 — settle delay after 0x01 (clear).
- `clk` in 1 — system clock; single clock domain.
- `rst` in 1 — asynchronous, active-high reset.
- `char_valid` in 1 — a character is offered.
- `char_data` in 8 — ASCII character code.
- `char_ready` out 1 — block can accept a character this cycle.
- `clear_req` in 1 — one-cycle pulse: clear the display and home the cursor.
- `init_done` out 1 — init sequence is complete; stays high until reset.
- `cursor_pos` out 5 — next write position, 0..31 (0–15 = line 1, 16–31 = line 2).
- `rs_out` out 1 — drives the controller's `rs_in`.
- `data_out` out 8 — drives the controller's `data_in`.
- `strobe_out` out 1 — drives the controller's `strobe_in`; one-cycle pulse.
- `period_clk_ns` out 8 — constant `CLK_PERIOD_NS[7:0]`.
- `ctrl_done` in 1 — the controller's `done`.

## Operation
- Delay cycles = `US*1000/CLK_PERIOD_NS`, computed at elaboration.
  - Defaults: 750000 / 2000 / 82000 cycles.
  - The delay counter is 20 bits wide. Parameter combinations that need more than 2^20−1 cycles are an elaboration error.
- States:
  - PWRUP_WAIT → ISSUE → WAIT_DONE → DELAY → (next ISSUE | IDLE)
  - IDLE → ISSUE on a clear or a character.
- Init ROM, all with `rs_out`=0: 0x28, 0x06, 0x0C, 0x01.
  - 0x01 uses `CLEAR_US`; the others use `CMD_US`.
  - After the last entry's DELAY: `init_done`=1, go to IDLE.
- ISSUE (one cycle):
  - `strobe_out`=1; `rs_out` and `data_out` valid.
  - `rs_out` and `data_out` hold their value until the next ISSUE.
- WAIT_DONE:
  - Advances on the first cycle with `ctrl_done`=1, starting the cycle after the strobe.
  - A `ctrl_done` in the strobe cycle itself is ignored.
- Character transfer:
  - Occurs when `char_valid && char_ready`.
  - Next cycle: ISSUE with `rs_out`=1, `data_out`=char.
  - After its DELAY: `cursor_pos` increments.
- `char_ready`=1 only when all hold: state is IDLE, `init_done`=1, no clear is pending, and `clear_req`=0 this cycle.
- Clear:
  - `clear_req` in any state sets `clear_pend`.
  - In IDLE, `clear_pend` (or a live `clear_req`) issues 0x01 with `CLEAR_US` delay.
  - Then `cursor_pos`=0 and `clear_pend` clears.
  - Clear beats a simultaneous character; that character stays pending and is not lost.
  - Several `clear_req` pulses while busy collapse into one clear.
- Reset mid-operation:
  - All state is abandoned and the block returns to PWRUP_WAIT.
  - The full init sequence replays.
- Reset values: `char_ready`=0, `init_done`=0, `cursor_pos`=0, `rs_out`=0, `data_out`=0x00, `strobe_out`=0, `clear_pend`=0. `period_clk_ns` is constant.

## Timing
- Character accepted in cycle N → `strobe_out` in cycle N+1.
- `char_ready` falls in cycle N+1. It rises again in the cycle after DELAY expires, following `ctrl_done`.
- `init_done` rises in the cycle after the 0x01 clear delay expires.
- There is no timeout on `ctrl_done`; the block waits indefinitely.
- Clear issued from IDLE: strobe appears in the cycle after `clear_req` is sampled.

## Configuration
- `LCD_SEQ_AUTOWRAP_EN` defined: after the character at position 15, the block issues 0xC0 (`rs_out`=0, `CMD_US`) before returning to IDLE, and `cursor_pos`=16.
  - After position 31 it issues 0x80 and `cursor_pos`=0.
  - `char_ready` stays low throughout that command.
- `LCD_SEQ_AUTOWRAP_EN` undefined: no cursor commands are issued. `cursor_pos` still increments modulo 32.

## Structure
- Shared package `lcd_pkg` holds:
  - the state enum;
  - command constants `LCD_CMD_FUNC4=8'h28`, `LCD_CMD_ENTRY=8'h06`, `LCD_CMD_DISP_ON=8'h0C`, `LCD_CMD_CLEAR=8'h01`, `LCD_CMD_LINE1=8'h80`, `LCD_CMD_LINE2=8'hC0`;
  - the `us_to_cycles` function.
- One sub-module, `lcd_delay_timer`: 20-bit down-counter with load and `expired` outputs, reused for all waits.

## Test plan
Bench uses `POWERUP_US`=2, `CMD_US`=1, `CLEAR_US`=3, `CLK_PERIOD_NS`=20, and a controller model that returns `done` 5 cycles after each strobe.
- Reset release → four strobes with `data_out` 0x28, 0x06, 0x0C, 0x01, all `rs_out`=0.
  - First strobe at cycle 100 after reset release.
  - `init_done`=1 exactly 150 cycles after the 0x01 done.
- After init, offer 'A' (0x41) → strobe the next cycle with `rs_out`=1, `data_out`=0x41.
  - `char_ready` returns to 1 50 cycles after done; `cursor_pos`=1.
- Write 16 chars with the macro defined → 0xC0 issued after the 16th char; `cursor_pos`=16.
  - Write 16 more → 0x80 issued; `cursor_pos`=0.
- `clear_req` and `char_valid` asserted in the same IDLE cycle → 0x01 strobes first.
  - The character is accepted after the clear delay and written at `cursor_pos`=0.
- Assert `rst` during the WAIT_DONE of the 0x0C command → all outputs return to their reset values immediately.
  - The sequence restarts from 0x28.
- `ctrl_done` held high in the strobe cycle → ignored.
  - WAIT_DONE advances only on a later `ctrl_done`.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types, LCD command codes and delay helpers for the HD44780 init sequencer.
package lcd_pkg;

    localparam int unsigned DLY_W = 20;

    typedef enum logic [2:0] {
        ST_PWRUP_WAIT,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_DELAY,
        ST_IDLE
    } seq_state_t;

    // What the in-flight strobe was, so DELAY knows where to go next.
    typedef enum logic [1:0] {
        OP_INIT,
        OP_CHAR,
        OP_CLEAR,
        OP_WRAP
    } seq_op_t;

    localparam logic [7:0] LCD_CMD_FUNC4   = 8'h28;
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_CMD_DISP_ON = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_LINE1   = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE2   = 8'hC0;

    localparam logic [1:0] INIT_LAST = 2'd3;

    function automatic longint unsigned us_to_cycles(input longint unsigned us,
                                                     input longint unsigned period_ns);
        return (us * 64'd1000) / period_ns;
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_CMD_FUNC4;
            2'd1:    return LCD_CMD_ENTRY;
            2'd2:    return LCD_CMD_DISP_ON;
            default: return LCD_CMD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// 20-bit load-and-count-down timer shared by every wait in the sequencer.
module lcd_delay_timer
    import lcd_pkg::*;
#(
    parameter logic [DLY_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DLY_W-1:0] load_val,
    output logic             expired
);

    logic [DLY_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (count_q != '0)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= RST_VAL;
        else     count_q <= count_d;
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/lcd_init_sequencer.sv
// HD44780 power-on / 4-bit init, then valid/ready character feed into lcd_controller.
// Define LCD_SEQ_AUTOWRAP_EN to issue line-change commands at the end of each line.
module lcd_init_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_PERIOD_NS = 20,
    parameter int unsigned POWERUP_US    = 15000,
    parameter int unsigned CMD_US        = 40,
    parameter int unsigned CLEAR_US      = 1640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    input  logic       clear_req,
    output logic       init_done,
    output logic [4:0] cursor_pos,
    output logic       rs_out,
    output logic [7:0] data_out,
    output logic       strobe_out,
    output logic [7:0] period_clk_ns,
    input  logic       ctrl_done
);

    localparam longint unsigned PWR_CYC = us_to_cycles(POWERUP_US, CLK_PERIOD_NS);
    localparam longint unsigned CMD_CYC = us_to_cycles(CMD_US, CLK_PERIOD_NS);
    localparam longint unsigned CLR_CYC = us_to_cycles(CLEAR_US, CLK_PERIOD_NS);
    localparam longint unsigned DLY_MAX = (64'd1 << DLY_W) - 64'd1;

    // The done cycle counts as the first settle cycle, hence the -2 on reload.
    localparam logic [DLY_W-1:0] PWR_LD = DLY_W'(PWR_CYC - 64'd1);
    localparam logic [DLY_W-1:0] CMD_LD = DLY_W'(CMD_CYC - 64'd2);
    localparam logic [DLY_W-1:0] CLR_LD = DLY_W'(CLR_CYC - 64'd2);

    generate
        if (PWR_CYC < 64'd1 || PWR_CYC > DLY_MAX ||
            CMD_CYC < 64'd2 || CMD_CYC > DLY_MAX ||
            CLR_CYC < 64'd2 || CLR_CYC > DLY_MAX) begin : g_bad_delay
            $error("lcd_init_sequencer: delay parameters do not fit the 20-bit timer");
        end
    endgenerate

    seq_state_t       state_q, state_d;
    seq_op_t          op_q, op_d;
    logic [1:0]       idx_q, idx_d;
    logic             init_done_q, init_done_d;
    logic [4:0]       cursor_q, cursor_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             clear_pend_q, clear_pend_d;

    logic             tmr_load;
    logic [DLY_W-1:0] tmr_val;
    logic             tmr_expired;
    logic             long_wait;

    lcd_delay_timer #(
        .RST_VAL (PWR_LD)
    ) u_delay_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    assign long_wait  = (op_q == OP_CLEAR) || (op_q == OP_INIT && idx_q == INIT_LAST);
    assign char_ready = (state_q == ST_IDLE) && init_done_q && !clear_pend_q && !clear_req;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        idx_d        = idx_q;
        init_done_d  = init_done_q;
        cursor_d     = cursor_q;
        rs_d         = rs_q;
        data_d       = data_q;
        clear_pend_d = clear_pend_q | clear_req;
        tmr_load     = 1'b0;
        tmr_val      = CMD_LD;

        unique case (state_q)
            ST_PWRUP_WAIT: begin
                if (tmr_expired) begin
                    state_d = ST_ISSUE;
                    op_d    = OP_INIT;
                    idx_d   = 2'd0;
                    rs_d    = 1'b0;
                    data_d  = init_cmd(2'd0);
                end
            end
            ST_ISSUE: state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                // Only reachable the cycle after the strobe, so a done in the strobe cycle is ignored.
                if (ctrl_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = long_wait ? CLR_LD : CMD_LD;
                    state_d  = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (tmr_expired) begin
                    state_d = ST_IDLE;
                    case (op_q)
                        OP_INIT: begin
                            if (idx_q == INIT_LAST) begin
                                init_done_d = 1'b1;
                            end else begin
                                idx_d   = idx_q + 2'd1;
                                data_d  = init_cmd(idx_q + 2'd1);
                                state_d = ST_ISSUE;
                            end
                        end
                        OP_CHAR: begin
                            cursor_d = cursor_q + 5'd1;
`ifdef LCD_SEQ_AUTOWRAP_EN
                            if (cursor_q == 5'd15 || cursor_q == 5'd31) begin
                                op_d    = OP_WRAP;
                                rs_d    = 1'b0;
                                data_d  = (cursor_q == 5'd15) ? LCD_CMD_LINE2 : LCD_CMD_LINE1;
                                state_d = ST_ISSUE;
                            end
`endif
                        end
                        OP_CLEAR: begin
                            cursor_d     = 5'd0;
                            clear_pend_d = clear_req;
                        end
                        default: ;
                    endcase
                end
            end
            ST_IDLE: begin
                // Clear wins; an offered character simply waits because char_ready is low.
                if (clear_pend_q || clear_req) begin
                    state_d = ST_ISSUE;
                    op_d    = OP_CLEAR;
                    rs_d    = 1'b0;
                    data_d  = LCD_CMD_CLEAR;
                end else if (char_valid && char_ready) begin
                    state_d = ST_ISSUE;
                    op_d    = OP_CHAR;
                    rs_d    = 1'b1;
                    data_d  = char_data;
                end
            end
            default: state_d = ST_PWRUP_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_PWRUP_WAIT;
            op_q         <= OP_INIT;
            idx_q        <= 2'd0;
            init_done_q  <= 1'b0;
            cursor_q     <= 5'd0;
            rs_q         <= 1'b0;
            data_q       <= 8'h00;
            clear_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            idx_q        <= idx_d;
            init_done_q  <= init_done_d;
            cursor_q     <= cursor_d;
            rs_q         <= rs_d;
            data_q       <= data_d;
            clear_pend_q <= clear_pend_d;
        end
    end

    assign init_done     = init_done_q;
    assign cursor_pos    = cursor_q;
    assign rs_out        = rs_q;
    assign data_out      = data_q;
    assign strobe_out    = (state_q == ST_ISSUE);
    assign period_clk_ns = CLK_PERIOD_NS[7:0];

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Directed bench: strobe scoreboard plus a controller model answering done 5 cycles after each strobe.
module tb_lcd_init_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       char_valid, clear_req, ctrl_done;
    logic [7:0] char_data;
    logic       char_ready, init_done, rs_out, strobe_out;
    logic [4:0] cursor_pos;
    logic [7:0] data_out, period_clk_ns;

    always #10 clk = ~clk;

    lcd_init_sequencer #(
        .CLK_PERIOD_NS (20),
        .POWERUP_US    (2),
        .CMD_US        (1),
        .CLEAR_US      (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .char_valid    (char_valid),
        .char_data     (char_data),
        .char_ready    (char_ready),
        .clear_req     (clear_req),
        .init_done     (init_done),
        .cursor_pos    (cursor_pos),
        .rs_out        (rs_out),
        .data_out      (data_out),
        .strobe_out    (strobe_out),
        .period_clk_ns (period_clk_ns),
        .ctrl_done     (ctrl_done)
    );

`ifdef LCD_SEQ_AUTOWRAP_EN
    localparam int WRAP_EXTRA = 1;
`else
    localparam int WRAP_EXTRA = 0;
`endif

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // cycle index since reset release
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Controller model: done 5 cycles after each strobe; optionally also in the strobe cycle.
    int   done_cnt;
    int   last_done_cyc = -1;
    logic early_done = 1'b0;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            ctrl_done = 1'b0;
            done_cnt  = 0;
        end else begin
            ctrl_done = 1'b0;
            if (strobe_out) begin
                done_cnt = 5;
                if (early_done) ctrl_done = 1'b1;
            end else if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    ctrl_done     = 1'b1;
                    last_done_cyc = cyc;
                end
            end
        end
    end

    // Scoreboard: {rs, data} expected per strobe, in order.
    logic [8:0] exp_q[$];
    int sr_cnt = 0;
    int first_cyc = -1;
    always @(negedge clk) begin
        if (rst) begin
            sr_cnt = 0;
        end else if (strobe_out) begin
            if (sr_cnt == 0) first_cyc = cyc;
            sr_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe_queue_size", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("strobe_rs_data", {23'd0, rs_out, data_out}, {23'd0, e});
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag, output int c);
        int k = 0;
        while (!char_ready && k < 3000) begin
            step();
            k++;
        end
        chk(tag, 32'(char_ready), 32'd1);
        c = cyc;
    endtask

    task automatic send_char(input logic [7:0] ch);
        int c;
        wait_ready("ready_before_char", c);
        char_valid = 1'b1;
        char_data  = ch;
        exp_q.push_back({1'b1, ch});
        step();
        char_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_char_ready"}, 32'(char_ready), 32'd0);
        chk({tag, "_init_done"},  32'(init_done),  32'd0);
        chk({tag, "_cursor"},     32'(cursor_pos), 32'd0);
        chk({tag, "_rs"},         32'(rs_out),     32'd0);
        chk({tag, "_data"},       32'(data_out),   32'd0);
        chk({tag, "_strobe"},     32'(strobe_out), 32'd0);
    endtask

    task automatic push_init();
        exp_q.push_back(9'h028);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
    endtask

    initial begin
        int c, k, b;
        char_valid = 1'b0;
        char_data  = 8'h00;
        clear_req  = 1'b0;
        repeat (3) step();
        check_reset("reset");
        chk("period_clk_ns", 32'(period_clk_ns), 32'd20);

        // First init, interrupted by reset while waiting on the 0x0C done.
        push_init();
        rst = 1'b0;
        k = 0;
        while (sr_cnt < 3 && k < 1000) begin
            step();
            k++;
        end
        chk("reached_0C", 32'(data_out), 32'h0C);
        step();
        rst = 1'b1;
        #1;
        check_reset("rst_in_wait_done");
        exp_q.delete();
        push_init();
        step();
        step();
        rst = 1'b0;

        // Full replayed init.
        k = 0;
        while (!init_done && k < 5000) begin
            step();
            k++;
        end
        chk("init_done_set", 32'(init_done), 32'd1);
        chk("first_strobe_cycle", 32'(first_cyc), 32'd100);
        chk("init_done_after_clear", 32'(cyc), 32'(last_done_cyc + 150));
        chk("init_strobe_count", 32'(sr_cnt), 32'd4);
        chk("init_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("ready_after_init", 32'(char_ready), 32'd1);

        // Single character.
        send_char(8'h41);
        chk("A_strobe_next_cycle", 32'(strobe_out), 32'd1);
        chk("A_ready_low", 32'(char_ready), 32'd0);
        wait_ready("A_ready_back", c);
        chk("A_ready_cycle", 32'(c), 32'(last_done_cyc + 50));
        chk("A_cursor", 32'(cursor_pos), 32'd1);

        // Fill line 1.
        b = sr_cnt;
        for (int i = 1; i < 16; i++) begin
            send_char(8'(8'h41 + i));
            if (i == 15 && WRAP_EXTRA == 1) exp_q.push_back(9'h0C0);
        end
        wait_ready("line1_ready", c);
        chk("line1_ready_cycle", 32'(c), 32'(last_done_cyc + 50));
        chk("line1_cursor", 32'(cursor_pos), 32'd16);
        chk("line1_strobes", 32'(sr_cnt - b), 32'(15 + WRAP_EXTRA));

        // Fill line 2.
        b = sr_cnt;
        for (int i = 0; i < 16; i++) begin
            send_char(8'(8'h61 + i));
            if (i == 15 && WRAP_EXTRA == 1) exp_q.push_back(9'h080);
        end
        wait_ready("line2_ready", c);
        chk("line2_cursor", 32'(cursor_pos), 32'd0);
        chk("line2_strobes", 32'(sr_cnt - b), 32'(16 + WRAP_EXTRA));
        chk("line2_queue_drained", 32'(exp_q.size()), 32'd0);

        // Clear and character offered in the same IDLE cycle.
        send_char(8'h30);
        wait_ready("pre_clear_ready", c);
        clear_req  = 1'b1;
        char_valid = 1'b1;
        char_data  = 8'h5A;
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h15A);
        step();
        clear_req = 1'b0;
        chk("clear_strobe_next_cycle", 32'(strobe_out), 32'd1);
        chk("clear_ready_low", 32'(char_ready), 32'd0);
        wait_ready("Z_ready", c);
        chk("clear_ready_cycle", 32'(c), 32'(last_done_cyc + 150));
        chk("Z_cursor_at_accept", 32'(cursor_pos), 32'd0);
        step();
        char_valid = 1'b0;
        chk("Z_strobe", 32'(strobe_out), 32'd1);
        wait_ready("Z_done_ready", c);
        chk("Z_cursor_after", 32'(cursor_pos), 32'd1);

        // Two clear pulses while busy collapse into one clear.
        send_char(8'h51);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        exp_q.push_back(9'h001);
        wait_ready("collapse_ready", c);
        chk("collapse_ready_cycle", 32'(c), 32'(last_done_cyc + 150));
        chk("collapse_cursor", 32'(cursor_pos), 32'd0);
        b = sr_cnt;
        repeat (200) step();
        chk("collapse_no_second_clear", 32'(sr_cnt), 32'(b));
        chk("collapse_queue_drained", 32'(exp_q.size()), 32'd0);

        // ctrl_done in the strobe cycle must not advance WAIT_DONE.
        early_done = 1'b1;
        send_char(8'h45);
        early_done = 1'b0;
        wait_ready("early_done_ready", c);
        chk("early_done_ignored", 32'(c), 32'(last_done_cyc + 50));
        chk("early_done_cursor", 32'(cursor_pos), 32'd1);

        // Reset from IDLE with init complete and cursor non-zero.
        rst = 1'b1;
        #1;
        check_reset("rst_in_idle");
        step();
        chk("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
